mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one 32-bit MEM-stage access onto a 16-bit SRAM
// as a low-halfword phase followed by a high-halfword phase, freezing the
// pipeline via ready until the access completes.
module mem_access_ctrl #(
   parameter int unsigned BIT_NUMBER  = 32,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [BIT_NUMBER-1:0] address,
   input  logic [BIT_NUMBER-1:0] write_data,
   output logic [BIT_NUMBER-1:0] read_data,
   output logic                  ready,
   output logic [17:0]           sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [15:0]           sram_dq_in,
   output logic                  sram_we_n
);

   localparam int unsigned HALF_W  = 16;
   localparam int unsigned WORD_AW = 17;
   localparam int unsigned CNT_W   = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_wr;
   logic [WORD_AW-1:0]    r_word;
   logic [BIT_NUMBER-1:0] r_wdata;
   logic [BIT_NUMBER-1:0] r_read_data;
   logic [17:0]           r_sram_addr;
   logic [HALF_W-1:0]     r_dq_out;
   logic                  r_dq_oe;
   logic                  r_we_n;

   logic [1:0]            w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_wr_nxt;
   logic [WORD_AW-1:0]    w_word_nxt;
   logic [BIT_NUMBER-1:0] w_wdata_nxt;
   logic [BIT_NUMBER-1:0] w_read_nxt;
   logic [17:0]           w_sram_addr_nxt;
   logic [HALF_W-1:0]     w_dq_out_nxt;
   logic                  w_dq_oe_nxt;
   logic                  w_we_n_nxt;
   logic [BIT_NUMBER-1:0] w_offset;
   logic [WORD_AW-1:0]    w_req_word;
   logic                  w_req;

   // SRAM word index of the incoming request, wrapping modulo 2^17 words
   always_comb begin
      w_offset   = address - BIT_NUMBER'(BASE_ADDR);
      w_req_word = WORD_AW'(w_offset >> 2);
      w_req      = rd_en | wr_en;
   end

   // State register plus registered SRAM-side and read-data outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_wr        <= 1'b0;
         r_word      <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_we_n      <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_wr        <= w_wr_nxt;
         r_word      <= w_word_nxt;
         r_wdata     <= w_wdata_nxt;
         r_read_data <= w_read_nxt;
         r_sram_addr <= w_sram_addr_nxt;
         r_dq_out    <= w_dq_out_nxt;
         r_dq_oe     <= w_dq_oe_nxt;
         r_we_n      <= w_we_n_nxt;
      end
   end

   // Next state; SRAM outputs are computed for the state being entered
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_wr_nxt        = r_wr;
      w_word_nxt      = r_word;
      w_wdata_nxt     = r_wdata;
      w_read_nxt      = r_read_data;
      w_sram_addr_nxt = r_sram_addr;
      w_dq_out_nxt    = r_dq_out;
      w_dq_oe_nxt     = 1'b0;
      w_we_n_nxt      = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_state_nxt     = S_LOW;
               w_cnt_nxt       = '0;
               w_wr_nxt        = wr_en;
               w_word_nxt      = w_req_word;
               w_wdata_nxt     = write_data;
               w_sram_addr_nxt = {w_req_word, 1'b0};
               w_dq_oe_nxt     = wr_en;
               w_we_n_nxt      = ~wr_en;
               if (wr_en) begin
                  w_dq_out_nxt = write_data[HALF_W-1:0];
               end
            end
         end
         S_LOW: begin
            w_dq_oe_nxt = r_wr;
            w_we_n_nxt  = ~r_wr;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt     = S_HIGH;
               w_cnt_nxt       = '0;
               w_sram_addr_nxt = {r_word, 1'b1};
               if (r_wr) begin
                  w_dq_out_nxt = r_wdata[BIT_NUMBER-1:HALF_W];
               end else begin
                  w_read_nxt[HALF_W-1:0] = sram_dq_in;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
               if (!r_wr) begin
                  w_read_nxt[BIT_NUMBER-1:HALF_W] = sram_dq_in;
               end
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_dq_oe_nxt = r_wr;
               w_we_n_nxt  = ~r_wr;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Freeze the pipeline unless idle with no request or completing
   always_comb begin
      ready = ((r_state == S_IDLE) & ~rd_en & ~wr_en) | (r_state == S_DONE);
   end

   assign read_data   = r_read_data;
   assign sram_addr   = r_sram_addr;
   assign sram_dq_out = r_dq_out;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word-level reference memory, queue-based
// scoreboard, and a negedge monitor that checks each access's bus trace.
module tb_mem_access_ctrl;

   localparam int unsigned W    = 1;
   localparam int unsigned BASE = 1024;
   localparam int unsigned WIN  = 16;
   localparam int unsigned LAST = 2 * W + 3;

   typedef struct {
      logic        wr;
      logic [16:0] w;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        pl_en;
   logic [17:0] pl_addr;
   logic [15:0] pl_data;
   logic [15:0] sram [0:262143];

   logic [31:0] ref_mem [0:WIN-1];
   logic [31:0] last_read;
   acc_t        exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Latency-only instances at the extreme wait settings
   logic        l_rd, l_wr;
   logic [31:0] l_addr, l_wd;
   logic [31:0] rd0, rd15;
   logic        rdy0, rdy15;
   logic [17:0] sa0, sa15;
   logic [15:0] dqo0, dqo15, dqi0, dqi15;
   logic        oe0, oe15, wen0, wen15;

   always #5 clk = ~clk;

   mem_access_ctrl #(.BIT_NUMBER(32), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));

   mem_access_ctrl #(.BIT_NUMBER(32), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .rd_en(l_rd), .wr_en(l_wr), .address(l_addr),
      .write_data(l_wd), .read_data(rd0), .ready(rdy0),
      .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
      .sram_dq_in(dqi0), .sram_we_n(wen0));

   mem_access_ctrl #(.BIT_NUMBER(32), .BASE_ADDR(BASE), .WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .rst(rst), .rd_en(l_rd), .wr_en(l_wr), .address(l_addr),
      .write_data(l_wd), .read_data(rd15), .ready(rdy15),
      .sram_addr(sa15), .sram_dq_out(dqo15), .sram_dq_oe(oe15),
      .sram_dq_in(dqi15), .sram_we_n(wen15));

   function automatic logic [15:0] pat(input logic [17:0] a);
      return a[15:0] ^ 16'h3C3C;
   endfunction

   assign dqi0       = pat(sa0);
   assign dqi15      = pat(sa15);
   assign sram_dq_in = sram[sram_addr];

   // Halfword SRAM model: preload port or strobed write
   always @(posedge clk) begin
      if (pl_en) sram[pl_addr] <= pl_data;
      else if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: follows each access by cycle index from its request cycle
   logic mon_busy = 1'b0;
   int   k;
   acc_t cur;
   logic hi;
   always @(negedge clk) begin
      if (!rst) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (rd_en | wr_en) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_req: got request expected none at %0t", $time);
            end else begin
               cur      = exp_q.pop_front();
               mon_busy = 1'b1;
               k        = 0;
               check("ready_c0", 32'(ready), 32'd0);
               check("we_n_c0", 32'(sram_we_n), 32'd1);
            end
         end
      end else begin
         k++;
         if (k < int'(LAST)) begin
            hi = (k > int'(W) + 1);
            check("ready_busy", 32'(ready), 32'd0);
            check("sram_addr", 32'(sram_addr), 32'({cur.w, hi}));
            check("we_n", 32'(sram_we_n), 32'(!cur.wr));
            check("dq_oe", 32'(sram_dq_oe), 32'(cur.wr));
            if (cur.wr)
               check("dq_out", 32'(sram_dq_out), hi ? 32'(cur.wd[31:16]) : 32'(cur.wd[15:0]));
         end else begin
            check("ready_done", 32'(ready), 32'd1);
            check("we_n_done", 32'(sram_we_n), 32'd1);
            check("oe_done", 32'(sram_dq_oe), 32'd0);
            check("read_data", read_data, cur.exp_rd);
            mon_busy = 1'b0;
         end
      end
   end

   // Issue one access (called at posedge+1), update the reference, wait for completion
   task automatic do_acc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      acc_t e;
      logic [16:0] w;
      logic done;
      w = 17'((addr - BASE) >> 2);
      e.wr = wr; e.w = w; e.wd = wd;
      if (wr) begin
         e.exp_rd = last_read;
         ref_mem[w[3:0]] = wd;
      end else begin
         e.exp_rd = ref_mem[w[3:0]];
         last_read = e.exp_rd;
      end
      exp_q.push_back(e);
      rd_en = rd; wr_en = wr; address = addr; write_data = wd;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ready) begin done = 1'b1; break; end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: got no ready expected ready within 64 cycles");
      end
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   task automatic preload(input int idx, input logic [31:0] v);
      ref_mem[idx] = v;
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = 18'(2 * idx); pl_data = v[15:0];
      @(posedge clk); #1;
      pl_addr = 18'(2 * idx + 1); pl_data = v[31:16];
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   function automatic logic [31:0] mk_addr(input int idx, input int al);
      logic [31:0] off;
      case (al)
         1: off = 32'h0008_0000;
         2: off = 32'h0010_0000;
         3: off = 32'hFFF8_0000;
         default: off = 32'h0;
      endcase
      return 32'(BASE + 4 * idx) + off;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old5, nw5;
      int lat0, lat15;
      logic d0, d15;
      logic [31:0] cap0, cap15;
      logic [31:0] a;
      int op;

      rst = 1'b0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
      pl_en = 0; pl_addr = 0; pl_data = 0;
      l_rd = 0; l_wr = 0; l_addr = 0; l_wd = 0;
      last_read = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_read_data", read_data, 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_dq_out", 32'(sram_dq_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < int'(WIN); i++)
         preload(i, (i == 1) ? 32'h1234_5678 : $urandom);

      // Directed: write, read, back-to-back, both enables
      do_acc(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
      do_acc(1'b1, 1'b0, 32'd1028, 32'h0);
      do_acc(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D);
      do_acc(1'b1, 1'b0, 32'd1032, 32'h0);
      do_acc(1'b1, 1'b1, 32'd1036, 32'hA5A5_5A5A);
      do_acc(1'b1, 1'b0, 32'd1036, 32'h0);
      do_acc(1'b1, 1'b0, 32'd1024, 32'h0);

      // Random traffic with aliased addresses and random gaps
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 2));
         a  = mk_addr(int'($urandom_range(0, WIN - 1)), int'($urandom_range(0, 3)));
         do_acc(op != 1, op != 0, a, $urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // Reset during the high phase of a write
      old5 = ref_mem[5];
      nw5  = ~old5;
      exp_q.push_back('{wr: 1'b1, w: 17'd5, wd: nw5, exp_rd: last_read});
      wr_en = 1'b1; address = 32'(BASE + 20); write_data = nw5;
      repeat (3) @(posedge clk);
      #2;
      check("high_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b0; wr_en = 1'b0;
      #1;
      check("abort_we_n", 32'(sram_we_n), 32'd1);
      check("abort_oe", 32'(sram_dq_oe), 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_read_data", read_data, 32'd0);
      ref_mem[5] = {old5[31:16], nw5[15:0]};
      last_read  = 32'd0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      do_acc(1'b0, 1'b1, 32'(BASE + 24), 32'h0BAD_F00D);
      do_acc(1'b1, 1'b0, 32'(BASE + 20), 32'h0);
      do_acc(1'b1, 1'b0, 32'(BASE + 24), 32'h0);

      // Latency at W=0 and W=15
      @(posedge clk); #1;
      l_rd = 1'b1; l_addr = 32'(BASE + 28);
      d0 = 0; d15 = 0; lat0 = -1; lat15 = -1; cap0 = 0; cap15 = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (!d0 && rdy0) begin d0 = 1; lat0 = c; cap0 = rd0; end
         if (!d15 && rdy15) begin d15 = 1; lat15 = c; cap15 = rd15; end
         if (d0 && d15) break;
      end
      l_rd = 1'b0;
      check("lat_w0", 32'(lat0), 32'd3);
      check("lat_w15", 32'(lat15), 32'd33);
      check("rd_w0", cap0, {pat(18'd15), pat(18'd14)});
      check("rd_w15", cap15, {pat(18'd15), pat(18'd14)});

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
